// File: rtl/hcu_scheduler.sv
// Hazard control unit: operand forwarding, load-use and memory-wait stalls,
// redirect flushes, memory-timeout error and stall/flush performance counters.
//
// state | meaning
// RUN   | normal issue; load-use and redirect resolved combinationally
// MWAIT | data memory busy; whole pipe held, wait_cnt counts wait cycles
// ERR   | memory timed out; pipe frozen, mem_err held until reset
module hcu_scheduler #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       A1_E,
  input  logic [4:0]       A2_E,
  input  logic [4:0]       A3_W,
  input  logic             RegWE_E_W,
  input  logic [4:0]       A4_W,
  input  logic             RegWE_W_W,
  input  logic [4:0]       A4_W2,
  input  logic             RegWE_W_W2,
  input  logic             MemAccessW,
  input  logic             mem_ready,
  input  logic [1:0]       PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       load_use;
  logic       front_stall;
  logic       redirect;

  // Writeback result takes priority over the load-stall buffer; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] a3,
                                         input logic we_e, input logic [4:0] a4w2,
                                         input logic we_w2);
    if (src == 5'd0)              return 2'b00;
    else if (we_e && src == a3)   return 2'b01;
    else if (we_w2 && src == a4w2) return 2'b10;
    else                          return 2'b00;
  endfunction

  always_comb begin
    mem_stall = 1'b1;
    case (state)
      RUN:     mem_stall = MemAccessW & ~mem_ready;
      MWAIT:   mem_stall = ~mem_ready;
      default: mem_stall = 1'b1;
    endcase
    load_use = ~mem_stall & RegWE_W_W & (A4_W != 5'd0) &
               ((A4_W == A1_E) | (A4_W == A2_E));
    front_stall = mem_stall | load_use;
    redirect    = ~front_stall & (PCSrcE != 2'b00);
  end

  assign StallF = front_stall;
  assign StallD = front_stall;
  assign StallE = front_stall;
  assign StallW = mem_stall;
  assign FlushD = redirect;
  assign FlushE = redirect;
  assign FlushW = load_use;
  assign fwdA_E = fwd_sel(A1_E, A3_W, RegWE_E_W, A4_W2, RegWE_W_W2);
  assign fwdB_E = fwd_sel(A2_E, A3_W, RegWE_E_W, A4_W2, RegWE_W_W2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (MemAccessW && !mem_ready) begin
            state    <= MWAIT;
            wait_cnt <= 8'd1;
          end
        end
        MWAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state   <= ERR;
          mem_err <= 1'b1;
        end
      endcase
      if (state != ERR) begin
        stall_cnt <= stall_cnt + CNT_W'(StallF);
        flush_cnt <= flush_cnt + CNT_W'(FlushE);
      end
    end
  end

endmodule

// File: doc/hcu_scheduler.md
HCU_SCHEDULER -- requirements
Module: hcu_scheduler

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of consecutive memory-wait cycles before an error is declared (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, the width of the performance counters.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- A1_E, A2_E  in  5  source registers of the Execute instruction.
- A3_W  in  5  destination register of the Execute-path writer now in Writeback.
- RegWE_E_W  in  1  the Writeback instruction's ALU/BNN result is valid for forwarding.
- A4_W  in  5  load destination register in Writeback.
- RegWE_W_W  in  1  a load is in Writeback.
- A4_W2  in  5  load-stall-buffer destination register.
- RegWE_W_W2  in  1  the load-stall-buffer entry is valid.
- MemAccessW  in  1  a load or store is in Writeback.
- mem_ready  in  1  the data memory completes the current access this cycle.
- PCSrcE  in  2  non-zero means the Execute instruction redirects the PC.
- StallF, StallD, StallE, StallW  out  1  per-stage hold.
- FlushD, FlushE, FlushW  out  1  per-stage bubble insert.
- fwdA_E, fwdB_E  out  2  operand forward selects: 00 = register file, 01 = ALUResultW, 10 = ReadData2.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-004 SHALL implement a registered FSM with states RUN, MWAIT and ERR; all stall, flush and forward outputs SHALL be combinational from the state and the inputs.
REQ-005 Forward select per operand: if the operand is x0, 00; else if it equals A3_W and RegWE_E_W is high, 01; else if it equals A4_W2 and RegWE_W_W2 is high, 10; else 00. Writeback has priority over W2.
REQ-006 Load-use: in RUN, when RegWE_W_W is high and A4_W is non-zero and equals A1_E or A2_E, the block SHALL assert StallF, StallD, StallE and FlushW for exactly one cycle. The next cycle forwards the value from W2 (10).
REQ-007 Memory wait: in RUN, when MemAccessW is high and mem_ready is low, the block SHALL go to MWAIT, assert StallF, StallD, StallE and StallW in that same cycle, and load wait_cnt with 1.
REQ-008 In MWAIT, all four stalls SHALL stay high while mem_ready is low, and wait_cnt SHALL increment each cycle.
REQ-009 In MWAIT, when mem_ready rises, the block SHALL return to RUN. In that same cycle stalls are deasserted, wait_cnt is cleared, and the load-use check of REQ-006 applies.
REQ-010 If mem_ready is still low when wait_cnt equals MEM_TIMEOUT, the block SHALL go to ERR. ERR holds all four stalls high and mem_err high until reset.
REQ-011 Redirect: when PCSrcE is non-zero and no stall is asserted this cycle, FlushD and FlushE SHALL be asserted for one cycle. The redirect is suppressed while any stall is active; the branch stays held in Execute and re-evaluates when released.
REQ-012 Priority SHALL be, highest first: ERR, MWAIT / memory wait, load-use, redirect. Simultaneous load-use and memory wait SHALL resolve as memory wait only.
REQ-013 A stage SHALL never have its Stall and Flush asserted in the same cycle.
REQ-014 stall_cnt SHALL increment by 1 in every cycle in which StallF is high.
REQ-015 flush_cnt SHALL increment by 1 in every cycle in which FlushE is high.
REQ-016 Both counters SHALL wrap modulo 2^CNT_W; neither counter increments in ERR.

Reset
REQ-017 While reset is low, the following SHALL hold asynchronously: state RUN, wait_cnt 0, mem_err 0, stall_cnt 0, flush_cnt 0.
REQ-018 Immediately after reset, with all inputs at 0, all stall and flush outputs SHALL be 0 and fwdA_E and fwdB_E SHALL be 00.
REQ-019 Reset asserted during MWAIT or ERR SHALL return the block to RUN and clear mem_err within the reset assertion, with no residual stall after reset deasserts.

Verification
REQ-020 Forwarding: A1_E=5, A3_W=5, RegWE_E_W=1, A4_W2=5, RegWE_W_W2=1 -> fwdA_E=01. Then RegWE_E_W=0 -> fwdA_E=10. Then A1_E=0 -> fwdA_E=00.
REQ-021 Load-use: RegWE_W_W=1, A4_W=7, A2_E=7 for one cycle -> StallF/D/E=1 and FlushW=1 in that cycle. Next cycle, with A4_W2=7 and RegWE_W_W2=1 -> stalls 0 and fwdB_E=10; stall_cnt=1.
REQ-022 Memory wait: MemAccessW=1, mem_ready=0 for 3 cycles, then 1 -> all four stalls high for 3 cycles, RUN on the 4th, stall_cnt=3, mem_err=0.
REQ-023 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> ERR entered after 4 wait cycles, mem_err=1 and remains 1 when mem_ready later rises. Reset low -> mem_err=0 and stalls 0.
REQ-024 Redirect vs stall: PCSrcE=01 coincident with a load-use hazard -> cycle 1: stalls only, FlushD/E=0. Cycle 2: FlushD=FlushE=1, flush_cnt=1.
